pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_segment.sv | 32 +++
 rtl/pipelined_adder.sv | 114 +++++++++++
 tb/tb_pipelined_adder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared sizing defaults and helpers for the segmented pipelined adder.
// Both the top level and the segment cell import this package.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEG   = 4;

  function automatic int calc_stages(input int width, input int seg);
    return (seg > 0) ? (width / seg) : 0;
  endfunction

  // A split is usable only if every stage gets a full segment.
  function automatic bit legal_split(input int width, input int seg);
    return (seg > 0) && (width > 0) && ((width % seg) == 0) && ((width / seg) >= 1);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// SEG-bit ripple-carry slice; also reports the carry into its top bit so the
// final slice can derive signed overflow.
module adder_segment
  import adder_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);

  logic carry;

  always_comb begin
    carry    = cin;
    sum      = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) begin
        c_msb_in = carry;
      end
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Segmented add/subtract pipeline: one SEG-bit slice per stage, carries
// registered between stages, with a valid chain and a single global stall.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carry_In,
  input  logic             Sub,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_Out,
  output logic             Overflow,
  output logic             Out_Valid,
  input  logic             Out_Ready
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  if (!legal_split(WIDTH, SEG)) begin : g_bad_split
    $error("pipelined_adder: WIDTH must be a positive integer multiple of SEG");
  end

  logic en;

  // Per-stage inputs (combinational) and registered state. Operand words are
  // carried whole; each stage only consumes its own slice of them.
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic             v_in  [STAGES];

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
  logic             ovf_q [STAGES];

  // The whole pipe advances together; it only stalls when the output slot is
  // occupied and the consumer is not taking it.
  assign en       = !Out_Valid || Out_Ready;
  assign In_Ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;
    logic             seg_cmsb;
    logic [WIDTH-1:0] s_nxt;

    if (k == 0) begin : g_head
      // Subtraction is A + ~B + 1, so the external carry is overridden.
      assign a_in[k] = A;
      assign b_in[k] = Sub ? ~B : B;
      assign c_in[k] = Sub | Carry_In;
      assign v_in[k] = In_Valid;
      assign s_in[k] = '0;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = v_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a        (a_in[k][k*SEG +: SEG]),
      .b        (b_in[k][k*SEG +: SEG]),
      .cin      (c_in[k]),
      .sum      (seg_sum),
      .cout     (seg_cout),
      .c_msb_in (seg_cmsb)
    );

    always_comb begin
      s_nxt                = s_in[k];
      s_nxt[k*SEG +: SEG]  = seg_sum;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        ovf_q[k] <= 1'b0;
      end else if (en) begin
        v_q[k]   <= v_in[k];
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        s_q[k]   <= s_nxt;
        c_q[k]   <= seg_cout;
        ovf_q[k] <= seg_cmsb ^ seg_cout;
      end
    end
  end

  // Only the final slice's overflow is meaningful; it sees the true top bit.
  assign Sum       = s_q[STAGES-1];
  assign Carry_Out = c_q[STAGES-1];
  assign Overflow  = ovf_q[STAGES-1];
  assign Out_Valid = v_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, SEG=4): directed vectors,
// a stalled stream, and a reset with requests in flight.
module tb_pipelined_adder;

  localparam int W = 16;

  logic         Clk;
  logic         Reset_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Carry_In;
  logic         Sub;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] Sum;
  logic         Carry_Out;
  logic         Overflow;
  logic         Out_Valid;
  logic         Out_Ready;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           lat;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t         exp_q[$];
  exp_t         e_cur;
  vec_t         vecs[10];
  logic [W-1:0] stream_exp[8];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  bit           held;
  logic [W-1:0] held_sum;
  logic         held_c;
  logic         held_o;

  pipelined_adder #(
    .WIDTH (16),
    .SEG   (4)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .A         (A),
    .B         (B),
    .Carry_In  (Carry_In),
    .Sub       (Sub),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Sum       (Sum),
    .Carry_Out (Carry_Out),
    .Overflow  (Overflow),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Monitor: pops one expectation per output handshake, and checks that a
  // stalled result does not change while it waits.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      held = 1'b0;
    end else if (Out_Valid) begin
      if (held) begin
        chk("hold_sum", 32'(Sum), 32'(held_sum));
        chk("hold_cout", 32'(Carry_Out), 32'(held_c));
        chk("hold_ovf", 32'(Overflow), 32'(held_o));
      end
      if (Out_Ready) begin
        chk("expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e_cur = exp_q.pop_front();
          chk("sum", 32'(Sum), 32'(e_cur.sum));
          chk("carry_out", 32'(Carry_Out), 32'(e_cur.cout));
          chk("overflow", 32'(Overflow), 32'(e_cur.ovf));
          if (e_cur.lat) chk("latency", 32'(cyc - e_cur.acc), 32'd4);
        end
      end
      held     = !Out_Ready;
      held_sum = Sum;
      held_c   = Carry_Out;
      held_o   = Overflow;
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sb, input logic [W-1:0] es, input logic ec,
                      input logic eo, input bit lat);
    exp_t e;
    bit   done = 1'b0;
    A        = a;
    B        = b;
    Carry_In = ci;
    Sub      = sb;
    In_Valid = 1'b1;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge Clk);
      if (In_Ready) begin
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        e.acc  = cyc;
        e.lat  = lat;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge Clk);
      #1;
    end
    In_Valid = 1'b0;
    chk("accept_in_time", 32'(done), 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge Clk);
      n++;
    end
    #1;
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;

    //          A         B         cin   sub   Sum       Cout  Ovf
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    stream_exp = '{16'h0101, 16'h0102, 16'h0103, 16'h0104,
                   16'h0105, 16'h0106, 16'h0107, 16'h0108};

    Reset_n   = 1'b0;
    A         = '0;
    B         = '0;
    Carry_In  = 1'b0;
    Sub       = 1'b0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;

    #1;
    chk("reset_out_valid", 32'(Out_Valid), 32'd0);
    chk("reset_in_ready", 32'(In_Ready), 32'd1);
    chk("reset_sum", 32'(Sum), 32'd0);
    chk("reset_cout", 32'(Carry_Out), 32'd0);
    chk("reset_ovf", 32'(Overflow), 32'd0);

    repeat (2) @(posedge Clk);
    #3 Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Directed vectors back to back, no stalls: each must take exactly 4 cycles.
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
           vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b1);
    end
    drain("vectors");

    // Streamed requests with the consumer stalling for three cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [W-1:0] a_val;
          a_val = W'(i + 1);
          send(a_val, 16'h0100, 1'b0, 1'b0, stream_exp[i], 1'b0, 1'b0, 1'b0);
        end
      end
      begin
        repeat (6) @(posedge Clk);
        #1 Out_Ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge Clk);
          chk("stall_in_ready", 32'(In_Ready), 32'd0);
          chk("stall_out_valid", 32'(Out_Valid), 32'd1);
          @(posedge Clk);
          #1;
        end
        Out_Ready = 1'b1;
      end
    join
    drain("stream");

    // Three requests in flight, then an asynchronous reset mid-cycle.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    send(16'h4444, 16'h1111, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    send(16'h0F00, 16'h00F0, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(Out_Valid), 32'd0);
    chk("midrst_in_ready", 32'(In_Ready), 32'd1);
    chk("midrst_sum", 32'(Sum), 32'd0);
    chk("midrst_cout", 32'(Carry_Out), 32'd0);
    chk("midrst_ovf", 32'(Overflow), 32'd0);
    repeat (2) @(posedge Clk);
    #3 Reset_n = 1'b1;

    stale = 0;
    repeat (8) begin
      @(negedge Clk);
      if (Out_Valid) stale++;
    end
    chk("stale_after_reset", 32'(stale), 32'd0);
    @(posedge Clk);
    #1;

    send(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b1);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
